// File: rtl/fetch_buffer.sv
// fetch_buffer: circular instruction buffer between fetch and decode.
// Holds up to DEPTH {pc, instr} pairs in program order and presents the
// oldest pair to decode. A flush discards everything buffered. All outputs
// come from registered state only, so there is no input-to-output path.
module fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [63:0]              i_in_pc,
  input  logic [31:0]              i_in_instr,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [63:0]              o_out_pc,
  output logic [31:0]              o_out_instr,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [31:0]   NOP_INSN = 32'h0000_0013;

  logic [63:0]   r_pc    [DEPTH];
  logic [31:0]   r_instr [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

  assign w_in_ready  = (r_count != FULL);
  assign w_out_valid = (r_count != '0);

  // A flush wins over both handshakes: neither the push nor the pop lands.
  assign w_push = i_in_valid  & w_in_ready  & ~i_flush;
  assign w_pop  = w_out_valid & i_out_ready & ~i_flush;

  // Occupancy update; simultaneous push and pop leave it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointer and count state; pointers wrap by natural overflow.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_nxt;
    end
  end

  // Entry storage; contents are never cleared, only the pointers are.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst) begin
      r_pc[r_wptr]    <= i_in_pc;
      r_instr[r_wptr] <= i_in_instr;
    end
  end

  // Head presentation; an empty buffer shows pc 0 and a canonical nop.
  always_comb begin
    o_out_pc    = 64'h0;
    o_out_instr = NOP_INSN;
    if (w_out_valid) begin
      o_out_pc    = r_pc[r_rptr];
      o_out_instr = r_instr[r_rptr];
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = w_out_valid;
  assign o_count     = r_count;

endmodule
